ysyx_22050019_idu_pipe: RTL and testbench

Pipelined, parametrised RV32/RV64 decode stage. It sits between the IFU and EXU, with valid/ready handshakes on both sides. It reads the register file, and a per-register scoreboard blocks RAW hazards. It registers a decoded bundle for the EXU. Illegal instructions and ebreak are reported as flags for the downstream trap logic; no DPI call is made.

---
 rtl/ysyx_22050019_idu_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_22050019_idu_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_idu_pipe.sv
// rtl/ysyx_22050019_idu_pipe.sv - pipelined RV32/RV64 decode stage with per-register RAW scoreboard
module ysyx_22050019_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int HAS_M    = 1,
    parameter int SB_CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [7:0]      out_class,
    output logic            out_is_w,
    output logic            out_illegal,
    output logic            out_ebreak,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            sb_err,
    output logic [31:0]     stall_cnt
);

    localparam logic [7:0] CLS_SYS    = 8'h80;
    localparam logic [7:0] CLS_ALU    = 8'h40;
    localparam logic [7:0] CLS_CSR    = 8'h20;
    localparam logic [7:0] CLS_JALR   = 8'h10;
    localparam logic [7:0] CLS_JAL    = 8'h08;
    localparam logic [7:0] CLS_BRANCH = 8'h04;
    localparam logic [7:0] CLS_STORE  = 8'h02;
    localparam logic [7:0] CLS_LOAD   = 8'h01;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [XLEN-1:0] imm;
    logic        shamt_ok, wshamt_ok;
    logic        uses_rs1, uses_rs2, writes, illegal, ebreak, is_w, rd_we;
    logic [7:0]  cls;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'h000};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm   = XLEN'($signed(imm32));

    // RV32 has only a 5-bit shamt, so bit 25 must also be clear there
    assign shamt_ok  = (in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10) && !(XLEN == 32 && in_inst[25]);
    assign wshamt_ok = (in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10) && !in_inst[25];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        writes   = 1'b0;
        illegal  = 1'b0;
        is_w     = 1'b0;
        cls      = 8'h00;
        imm32    = 32'h0;
        case (opcode)
            7'h37, 7'h17: begin writes = 1'b1; cls = CLS_ALU; imm32 = imm_u; end
            7'h6f: begin writes = 1'b1; cls = CLS_JAL; imm32 = imm_j; end
            7'h67: begin writes = 1'b1; uses_rs1 = 1'b1; cls = CLS_JALR; imm32 = imm_i; end
            7'h63: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; cls = CLS_BRANCH; imm32 = imm_b; end
            7'h03: begin writes = 1'b1; uses_rs1 = 1'b1; cls = CLS_LOAD; imm32 = imm_i; end
            7'h23: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; cls = CLS_STORE; imm32 = imm_s; end
            7'h13: begin
                writes = 1'b1; uses_rs1 = 1'b1; cls = CLS_ALU; imm32 = imm_i;
                if (funct3 == 3'd1 || funct3 == 3'd5) illegal = !shamt_ok;
            end
            7'h1b: begin
                writes = 1'b1; uses_rs1 = 1'b1; cls = CLS_ALU; imm32 = imm_i; is_w = 1'b1;
                illegal = (XLEN == 32) || ((funct3 == 3'd1 || funct3 == 3'd5) && !wshamt_ok);
            end
            7'h33: begin
                writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; cls = CLS_ALU;
                illegal = (HAS_M == 0) && (funct7 == 7'h01);
            end
            7'h3b: begin
                writes = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; cls = CLS_ALU; is_w = 1'b1;
                illegal = (XLEN == 32) || ((HAS_M == 0) && (funct7 == 7'h01));
            end
            7'h73: begin
                imm32 = imm_i;
                if (funct3 == 3'd0) begin
                    cls = CLS_SYS;
                end else if (funct3 == 3'd1 || funct3 == 3'd2) begin
                    writes = 1'b1; uses_rs1 = 1'b1; cls = CLS_CSR;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // an illegal instruction traps: it reads nothing and reserves nothing
        if (illegal) begin
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
            writes   = 1'b0;
            is_w     = 1'b0;
            cls      = CLS_SYS;
        end
    end

    assign ebreak    = (in_inst == 32'h0010_0073);
    assign rd_we     = writes && (rd != 5'd0);
    assign rf_raddr1 = uses_rs1 ? rs1 : 5'd0;
    assign rf_raddr2 = uses_rs2 ? rs2 : 5'd0;

    logic [SB_CNT_W-1:0] sb_cnt [32];
    logic [SB_CNT_W-1:0] sb_nxt [32];
    logic                hazard, sb_full, accept;
    int                  sb_tmp;

    assign hazard   = (uses_rs1 && rs1 != 5'd0 && sb_cnt[rs1] != '0) ||
                      (uses_rs2 && rs2 != 5'd0 && sb_cnt[rs2] != '0);
    assign sb_full  = rd_we && (&sb_cnt[rd]);
    assign in_ready = !hazard && !sb_full && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // a writeback against an empty counter is ignored (and flagged); flush+wb may net -2
    always_comb begin
        sb_tmp = 0;
        for (int i = 0; i < 32; i++) begin
            sb_tmp = int'(sb_cnt[i]);
            if (accept && rd_we && rd == 5'(i)) sb_tmp = sb_tmp + 1;
            if (wb_valid && i != 0 && wb_rd == 5'(i) && sb_cnt[i] != '0) sb_tmp = sb_tmp - 1;
            if (flush && out_valid && out_rd_we && out_rd == 5'(i)) sb_tmp = sb_tmp - 1;
            if (sb_tmp < 0) sb_tmp = 0;
            sb_nxt[i] = SB_CNT_W'(sb_tmp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) sb_cnt[i] <= '0;
            sb_err    <= 1'b0;
            stall_cnt <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) sb_cnt[i] <= sb_nxt[i];
            if (wb_valid && wb_rd != 5'd0 && sb_cnt[wb_rd] == '0) sb_err <= 1'b1;
            if (in_valid && hazard && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= 32'h0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_rd      <= 5'd0;
            out_rd_we   <= 1'b0;
            out_class   <= 8'h00;
            out_is_w    <= 1'b0;
            out_illegal <= 1'b0;
            out_ebreak  <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_rs1_val <= rf_rdata1;
            out_rs2_val <= rf_rdata2;
            out_imm     <= imm;
            out_rd      <= rd;
            out_rd_we   <= rd_we;
            out_class   <= cls;
            out_is_w    <= is_w;
            out_illegal <= illegal;
            out_ebreak  <= ebreak;
        end else if (flush || out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_idu_pipe.sv
// tb/tb_ysyx_22050019_idu_pipe.sv - randomized self-checking bench for the decode stage
module tb_ysyx_22050019_idu_pipe;
    localparam int XLEN     = 64;
    localparam int HAS_M    = 0;
    localparam int SB_CNT_W = 2;
    localparam int SB_MAX   = 3;
    localparam logic [7:0] K_SYS = 8'h80, K_ALU = 8'h40, K_CSR = 8'h20, K_JALR = 8'h10;
    localparam logic [7:0] K_JAL = 8'h08, K_BR = 8'h04, K_ST = 8'h02, K_LD = 8'h01;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_pc, out_pc, out_rs1_val, out_rs2_val, out_imm, rf_rdata1, rf_rdata2;
    logic [31:0] in_inst, out_inst, stall_cnt;
    logic [4:0]  rf_raddr1, rf_raddr2, out_rd, wb_rd;
    logic        out_rd_we, out_is_w, out_illegal, out_ebreak, wb_valid, flush, sb_err;
    logic [7:0]  out_class;

    logic [63:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    ysyx_22050019_idu_pipe #(.XLEN(XLEN), .HAS_M(HAS_M), .SB_CNT_W(SB_CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_class(out_class), .out_is_w(out_is_w),
        .out_illegal(out_illegal), .out_ebreak(out_ebreak), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic u1, u2, we, ill, ebk, isw;
        logic [7:0]  cls;
        logic [63:0] imm;
    } dec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] a, b, imm;
        logic [4:0]  rd;
        logic        we;
        logic [7:0]  cls;
        logic        isw, ill, ebk;
    } bun_t;

    int          checks = 0;
    int          failures = 0;
    logic        m_valid;
    bun_t        m_b;
    int          m_cnt [32];
    logic [31:0] m_stall;
    logic        m_err;
    int          pending [$];
    logic        last_ready;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode: straight from the ISA field rules
    function automatic dec_t dec(input logic [31:0] i);
        dec_t d;
        logic [2:0] f3;
        logic       sh_ok;
        f3    = i[14:12];
        sh_ok = (i[31:26] == 6'h00) || (i[31:26] == 6'h10);
        d     = '0;
        case (i[6:0])
            7'h37, 7'h17: begin d.we = 1; d.cls = K_ALU; d.imm = {{32{i[31]}}, i[31:12], 12'h0}; end
            7'h6f: begin d.we = 1; d.cls = K_JAL;
                   d.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin d.we = 1; d.u1 = 1; d.cls = K_JALR; d.imm = {{52{i[31]}}, i[31:20]}; end
            7'h63: begin d.u1 = 1; d.u2 = 1; d.cls = K_BR;
                   d.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h03: begin d.we = 1; d.u1 = 1; d.cls = K_LD; d.imm = {{52{i[31]}}, i[31:20]}; end
            7'h23: begin d.u1 = 1; d.u2 = 1; d.cls = K_ST; d.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
            7'h13: begin d.we = 1; d.u1 = 1; d.cls = K_ALU; d.imm = {{52{i[31]}}, i[31:20]};
                   if (f3 == 1 || f3 == 5) d.ill = !sh_ok; end
            7'h1b: begin d.we = 1; d.u1 = 1; d.cls = K_ALU; d.isw = 1; d.imm = {{52{i[31]}}, i[31:20]};
                   if (f3 == 1 || f3 == 5) d.ill = !sh_ok || i[25]; end
            7'h33, 7'h3b: begin d.we = 1; d.u1 = 1; d.u2 = 1; d.cls = K_ALU; d.isw = (i[6:0] == 7'h3b);
                   d.ill = (HAS_M == 0) && (i[31:25] == 7'h01); end
            7'h73: begin d.imm = {{52{i[31]}}, i[31:20]};
                   if (f3 == 0) d.cls = K_SYS;
                   else if (f3 == 1 || f3 == 2) begin d.we = 1; d.u1 = 1; d.cls = K_CSR; end
                   else d.ill = 1; end
            default: d.ill = 1;
        endcase
        if (d.ill) begin d.u1 = 0; d.u2 = 0; d.we = 0; d.isw = 0; d.cls = K_SYS; end
        d.ebk = (i == 32'h0010_0073);
        if (i[11:7] == 5'd0) d.we = 0;
        return d;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("sb_err", sb_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_valid) begin
            chk("out_pc", out_pc, m_b.pc);
            chk("out_inst", out_inst, m_b.inst);
            chk("out_rs1_val", out_rs1_val, m_b.a);
            chk("out_rs2_val", out_rs2_val, m_b.b);
            chk("out_imm", out_imm, m_b.imm);
            chk("out_rd", out_rd, m_b.rd);
            chk("out_rd_we", out_rd_we, m_b.we);
            chk("out_class", out_class, m_b.cls);
            chk("out_is_w", out_is_w, m_b.isw);
            chk("out_illegal", out_illegal, m_b.ill);
            chk("out_ebreak", out_ebreak, m_b.ebk);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_err   = 0;
        m_stall = 0;
        for (int k = 0; k < 32; k++) m_cnt[k] = 0;
        pending.delete();
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge
    task automatic step(input logic iv, input logic [31:0] inst, input logic [63:0] pc,
                        input logic ordy, input logic wv, input logic [4:0] wr, input logic fl);
        dec_t       d;
        logic [4:0] r1, r2, rdx;
        logic       hz, full, rdy, acc;
        int         nc [32];
        @(negedge clk);
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        wb_valid = wv; wb_rd = wr; flush = fl;
        #1;
        d   = dec(inst);
        r1  = inst[19:15];
        r2  = inst[24:20];
        rdx = inst[11:7];
        hz   = (d.u1 && r1 != 0 && m_cnt[r1] != 0) || (d.u2 && r2 != 0 && m_cnt[r2] != 0);
        full = d.we && m_cnt[rdx] == SB_MAX;
        rdy  = !hz && !full && !fl && (!m_valid || ordy);
        last_ready = in_ready;
        chk("in_ready", in_ready, rdy);
        chk("rf_raddr1", rf_raddr1, d.u1 ? r1 : 5'd0);
        chk("rf_raddr2", rf_raddr2, d.u2 ? r2 : 5'd0);
        acc = iv && rdy;
        @(posedge clk);
        if (wv && wr != 0 && m_cnt[wr] == 0) m_err = 1;
        for (int k = 0; k < 32; k++) nc[k] = m_cnt[k];
        if (acc && d.we) nc[rdx]++;
        if (wv && wr != 0 && m_cnt[wr] != 0) nc[wr]--;
        if (fl && m_valid && m_b.we) nc[m_b.rd]--;
        for (int k = 0; k < 32; k++) m_cnt[k] = (nc[k] < 0) ? 0 : nc[k];
        if (wv && wr != 0) begin
            for (int k = 0; k < pending.size(); k++)
                if (pending[k] == int'(wr)) begin pending.delete(k); break; end
        end
        if (iv && hz && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (m_valid && ordy && !fl && m_b.we) pending.push_back(int'(m_b.rd));
        if (acc) begin
            m_valid = 1;
            m_b = '{pc: pc, inst: inst, a: regs[d.u1 ? r1 : 5'd0], b: regs[d.u2 ? r2 : 5'd0],
                    imm: d.imm, rd: rdx, we: d.we, cls: d.cls, isw: d.isw, ill: d.ill, ebk: d.ebk};
        end else if (m_valid && (fl || ordy)) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 2))
            0: return 7'h00;
            1: return 7'h20;
            default: return 7'h01;
        endcase
    endfunction

    function automatic logic [5:0] pick_f6();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: return 6'h00;
            1: return 6'h10;
            default: return r[5:0];
        endcase
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [4:0]  a, b, d;
        logic [31:0] r;
        logic [2:0]  f3;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        r = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 14))
            0:  return {r[31:20], a, 3'b000, d, 7'h13};
            1:  return {pick_f7(), b, a, f3, d, 7'h33};
            2:  return {r[31:20], a, f3, d, 7'h03};
            3:  return {r[31:25], b, a, f3, r[11:7], 7'h23};
            4:  return {r[31:25], b, a, f3, r[11:7], 7'h63};
            5:  return {r[31:12], d, 7'h37};
            6:  return {r[31:12], d, 7'h17};
            7:  return {r[31:12], d, 7'h6f};
            8:  return {r[31:20], a, 3'b000, d, 7'h67};
            9:  return {r[31:20], a, f3, d, 7'h73};
            10: return ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
            11: return {pick_f6(), r[25:20], a, (r[12] ? 3'd5 : 3'd1), d, 7'h13};
            12: return {pick_f6(), r[25:20], a, f3, d, 7'h1b};
            13: return {pick_f7(), b, a, f3, d, 7'h3b};
            default: return r;
        endcase
    endfunction

    task automatic drain();
        for (int n = 0; n < 64 && pending.size() > 0; n++)
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 5'(pending[0]), 1'b0);
    endtask

    task automatic random_phase(input int cycles);
        logic       wv;
        logic [4:0] wr;
        for (int c = 0; c < cycles; c++) begin
            wv = 0;
            wr = 0;
            if (pending.size() > 0 && $urandom_range(0, 99) < 40) begin
                wv = 1;
                wr = 5'(pending[$urandom_range(0, pending.size() - 1)]);
            end
            step($urandom_range(0, 99) < 75, rnd_inst(), {$urandom, $urandom},
                 $urandom_range(0, 99) < 70, wv, wr, $urandom_range(0, 99) < 5);
        end
    endtask

    initial begin
        rst = 1;
        in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
        regs[0] = 64'h0;
        for (int k = 1; k < 32; k++) regs[k] = {$urandom, $urandom};
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_rd_we", out_rd_we, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // addi x1,x0,5
        step(1, 32'h0050_0093, 64'h8000_0000, 1, 0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_rd", out_rd, 1);
        chk("t1_rd_we", out_rd_we, 1);
        chk("t1_imm", out_imm, 5);
        chk("t1_class", out_class, 8'h40);
        chk("t1_pc", out_pc, 64'h8000_0000);

        // add x2,x1,x1 stalls on x1 until its writeback
        repeat (3) step(1, 32'h0010_8133, 64'h8000_0004, 1, 0, 0, 0);
        chk("t2_ready", last_ready, 0);
        chk("t2_stall", stall_cnt, 3);
        step(1, 32'h0010_8133, 64'h8000_0004, 1, 1, 5'd1, 0);
        chk("t2_wb_cycle_ready", last_ready, 0);
        step(1, 32'h0010_8133, 64'h8000_0004, 1, 0, 0, 0);
        chk("t2_accept", last_ready, 1);
        chk("t2_rd", out_rd, 2);
        chk("t2_rs1", out_rs1_val, regs[1]);
        chk("t2_stall_final", stall_cnt, 4);

        // backpressure holds the bundle
        for (int k = 0; k < 5; k++) begin
            step(1, 32'h0070_0193, 64'h8000_0008, 0, 0, 0, 0);
            chk("t3_ready", last_ready, 0);
            chk("t3_hold_inst", out_inst, 32'h0010_8133);
        end
        step(1, 32'h0070_0193, 64'h8000_0008, 1, 0, 0, 0);
        chk("t3_load_rd", out_rd, 3);
        chk("t3_load_imm", out_imm, 7);

        // flush kills addi x3 and releases its reservation
        step(0, 32'h0, 64'h0, 0, 0, 0, 1);
        chk("t4_ready", last_ready, 0);
        chk("t4_valid", out_valid, 0);
        step(1, 32'h0001_8233, 64'h8000_000c, 1, 0, 0, 0);
        chk("t4_x3_free", last_ready, 1);

        // mul with M disabled, then ebreak
        step(1, 32'h0231_00b3, 64'h8000_0010, 1, 0, 0, 0);
        chk("t5_illegal", out_illegal, 1);
        chk("t5_rd_we", out_rd_we, 0);
        chk("t5_class", out_class, 8'h80);
        step(1, 32'h0010_0073, 64'h8000_0014, 1, 0, 0, 0);
        chk("t5_ebreak", out_ebreak, 1);
        chk("t5_eb_class", out_class, 8'h80);
        drain();

        // three writers to x5 saturate its counter, the fourth stalls
        repeat (3) step(1, 32'h0010_0293, 64'h8000_0020, 1, 0, 0, 0);
        step(1, 32'h0010_0293, 64'h8000_0020, 1, 0, 0, 0);
        chk("t6_full", last_ready, 0);
        step(0, 32'h0, 64'h0, 1, 1, 5'd6, 0);
        chk("t6_sb_err", sb_err, 1);
        drain();

        random_phase(1500);

        // asynchronous reset with a bundle held
        step(1, 32'h0050_0493, 64'h8000_0100, 1, 0, 0, 0);
        @(negedge clk);
        in_valid = 0; out_ready = 0; wb_valid = 0; flush = 0;
        #2 rst = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_sb_err", sb_err, 0);
        model_reset();
        @(negedge clk);
        rst = 0;

        random_phase(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
